// File: rtl/sr_frame_reader.sv
// sr_frame_reader: drains the super-resolution output FIFO in fixed-length
// bursts and presents the pixels as a valid/ready stream tagged with
// start-of-frame, end-of-line and end-of-frame markers.
module sr_frame_reader #(
  parameter int WIDTH       = 320,
  parameter int HEIGHT      = 240,
  parameter int PIXEL_WIDTH = 24,
  parameter int BURST_LEN   = 16,
  parameter int COUNT_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [COUNT_WIDTH-1:0] data_count_r,
  input  logic [PIXEL_WIDTH-1:0] fifo_dout,
  output logic                   rd_fifo,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [PIXEL_WIDTH-1:0] m_data,
  output logic                   m_sof,
  output logic                   m_eol,
  output logic                   m_eof,
  output logic                   frame_done,
  output logic [15:0]            frame_count
);

  localparam int FRAME_SIZE = WIDTH * HEIGHT;
  localparam int IW  = $clog2(FRAME_SIZE + 1);
  localparam int XW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  // Burst arithmetic width: wide enough for the frame size, the fill count
  // and any legal burst length (up to 511).
  localparam int BW0 = (IW > COUNT_WIDTH) ? IW : COUNT_WIDTH;
  localparam int BW  = (BW0 > 10) ? BW0 : 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BURST,
    S_SETTLE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                 state_reg, state_next;
  logic [IW-1:0]          issued_reg;
  logic [BW-1:0]          burst_left_reg;
  logic                   settle_reg;
  logic [XW-1:0]          x_reg;
  logic [YW-1:0]          y_reg;
  logic                   rd_q_reg;
  logic [15:0]            frame_count_reg;

  // Two-entry re-timing buffer.
  logic [PIXEL_WIDTH-1:0] buf_mem [2];
  logic                   wr_ptr_reg;
  logic                   rd_ptr_reg;
  logic [1:0]             occ_reg;

  logic [BW-1:0]          remaining;
  logic [BW-1:0]          blen;
  logic                   frame_full;
  logic                   count_ok;
  logic                   pop;
  logic                   push;
  logic                   space;
  logic [2:0]             fill;
  logic [2:0]             limit;
  logic                   at_eol;
  logic                   at_last_line;

  assign remaining    = BW'(FRAME_SIZE) - BW'(issued_reg);
  assign blen         = (remaining < BW'(BURST_LEN)) ? remaining : BW'(BURST_LEN);
  assign frame_full   = (issued_reg == IW'(FRAME_SIZE));
  assign count_ok     = (BW'(data_count_r) >= blen);
  assign m_valid      = (occ_reg != 2'd0);
  assign pop          = m_valid && m_ready;
  assign push         = rd_q_reg;
  assign at_eol       = (x_reg == XW'(WIDTH - 1));
  assign at_last_line = (y_reg == YW'(HEIGHT - 1));

  // Space check counts buffered pixels plus the read still in flight,
  // crediting a pop happening this cycle, so the buffer can never overflow.
  assign fill  = {1'b0, occ_reg} + {2'b00, rd_q_reg};
  assign limit = 3'd2 + {2'b00, pop};
  assign space = (fill < limit);

  assign m_data      = m_valid ? buf_mem[rd_ptr_reg] : '0;
  assign m_sof       = m_valid && (x_reg == '0) && (y_reg == '0);
  assign m_eol       = m_valid && at_eol;
  assign m_eof       = m_valid && at_eol && at_last_line;
  assign frame_done  = (state_reg == S_DONE);
  assign frame_count = frame_count_reg;

  // Next-state and read-strobe decode.
  always_comb begin
    state_next = state_reg;
    rd_fifo    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (frame_full) begin
          state_next = S_DRAIN;
        end else if (((issued_reg != '0) || enable) && count_ok) begin
          state_next = S_BURST;
        end
      end
      S_BURST: begin
        rd_fifo = !rst && (burst_left_reg != '0) && space;
        if (rd_fifo && (burst_left_reg == BW'(1))) begin
          state_next = S_SETTLE;
        end
      end
      S_SETTLE: begin
        // The last pixel of a frame can already be leaving on the second
        // settle cycle; go straight to DONE so the pulse is not delayed.
        if (settle_reg) begin
          if (!frame_full) begin
            state_next = S_IDLE;
          end else if (pop && m_eof) begin
            state_next = S_DONE;
          end else begin
            state_next = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (pop && m_eof) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State register and read-side counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      issued_reg      <= '0;
      burst_left_reg  <= '0;
      settle_reg      <= 1'b0;
      rd_q_reg        <= 1'b0;
      frame_count_reg <= 16'd0;
    end else begin
      state_reg  <= state_next;
      rd_q_reg   <= rd_fifo;
      settle_reg <= (state_reg == S_SETTLE) ? ~settle_reg : 1'b0;
      if ((state_reg == S_IDLE) && (state_next == S_BURST)) begin
        burst_left_reg <= blen;
      end else if (rd_fifo) begin
        burst_left_reg <= burst_left_reg - BW'(1);
      end
      if (state_reg == S_DONE) begin
        issued_reg      <= '0;
        frame_count_reg <= frame_count_reg + 16'd1;
      end else if (rd_fifo) begin
        issued_reg <= issued_reg + IW'(1);
      end
    end
  end

  // Buffer storage: capture FIFO data the cycle after each read.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_mem[wr_ptr_reg] <= fifo_dout;
    end
  end

  // Buffer pointers and occupancy; push and pop in one cycle cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      occ_reg    <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      case ({push, pop})
        2'b10:   occ_reg <= occ_reg + 2'd1;
        2'b01:   occ_reg <= occ_reg - 2'd1;
        default: occ_reg <= occ_reg;
      endcase
    end
  end

  // Output pixel position, advanced on each accepted pixel.
  always_ff @(posedge clk) begin
    if (rst || (state_reg == S_DONE)) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (pop) begin
      if (at_eol) begin
        x_reg <= '0;
        y_reg <= at_last_line ? '0 : (y_reg + YW'(1));
      end else begin
        x_reg <= x_reg + XW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sr_frame_reader.sv
// Testbench for sr_frame_reader: two instances (8x4 frame with 16-read bursts,
// 4x3 frame with 8-read bursts) fed from behavioural FIFO models.
module tb_sr_frame_reader;

  localparam int WA = 8, HA = 4, FS_A = WA * HA;
  localparam int WB = 4, HB = 3, FS_B = WB * HB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int pass_cnt = 0;
  int total_cnt = 0;

  // Instance A signals
  logic        rst_a = 1'b1, en_a = 1'b0, rdy_a = 1'b0;
  logic [9:0]  dc_a;
  logic [23:0] dout_a = '0;
  logic        rd_a, val_a, sof_a, eol_a, eof_a, done_a;
  logic [23:0] data_a;
  logic [15:0] fcnt_a;
  // Instance B signals
  logic        rst_b = 1'b1, en_b = 1'b0, rdy_b = 1'b0;
  logic [9:0]  dc_b;
  logic [23:0] dout_b = '0;
  logic        rd_b, val_b, sof_b, eol_b, eof_b, done_b;
  logic [23:0] data_b;
  logic [15:0] fcnt_b;

  // FIFO models: pixels src[consumed..produced-1] are in the FIFO.
  logic [23:0] src_a [256];
  logic [23:0] src_b [256];
  int produced_a = 0, consumed_a = 0, produced_b = 0, consumed_b = 0;
  logic rd_pend_a = 1'b0, rd_pend_b = 1'b0;
  int empty_rd_a = 0, empty_rd_b = 0;
  assign dc_a = 10'(produced_a - consumed_a);
  assign dc_b = 10'(produced_b - consumed_b);

  // Observation logs
  int          rd_cyc_a[$], rd_cyc_b[$];
  logic [26:0] obs_a[$], obs_b[$];
  int          hs_cyc_a[$], hs_cyc_b[$];
  int          done_cyc_a[$], done_cyc_b[$];
  int          burst_rd_base;

  sr_frame_reader #(.WIDTH(WA), .HEIGHT(HA), .PIXEL_WIDTH(24), .BURST_LEN(16), .COUNT_WIDTH(10)) dut_a (
    .clk(clk), .rst(rst_a), .enable(en_a), .data_count_r(dc_a), .fifo_dout(dout_a),
    .rd_fifo(rd_a), .m_valid(val_a), .m_ready(rdy_a), .m_data(data_a), .m_sof(sof_a),
    .m_eol(eol_a), .m_eof(eof_a), .frame_done(done_a), .frame_count(fcnt_a));

  sr_frame_reader #(.WIDTH(WB), .HEIGHT(HB), .PIXEL_WIDTH(24), .BURST_LEN(8), .COUNT_WIDTH(10)) dut_b (
    .clk(clk), .rst(rst_b), .enable(en_b), .data_count_r(dc_b), .fifo_dout(dout_b),
    .rd_fifo(rd_b), .m_valid(val_b), .m_ready(rdy_b), .m_data(data_b), .m_sof(sof_b),
    .m_eol(eol_b), .m_eof(eof_b), .frame_done(done_b), .frame_count(fcnt_b));

  // FIFO read data appears the cycle after the strobe.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_pend_a) begin
      dout_a     <= src_a[consumed_a];
      consumed_a <= consumed_a + 1;
    end
    if (rd_pend_b) begin
      dout_b     <= src_b[consumed_b];
      consumed_b <= consumed_b + 1;
    end
  end

  // Mid-cycle monitor: logs reads, handshakes and frame_done pulses.
  always @(negedge clk) begin
    rd_pend_a = rd_a;
    rd_pend_b = rd_b;
    if (rd_a) begin
      rd_cyc_a.push_back(cyc);
      if (produced_a == consumed_a) empty_rd_a++;
    end
    if (rd_b) begin
      rd_cyc_b.push_back(cyc);
      if (produced_b == consumed_b) empty_rd_b++;
    end
    if (val_a && rdy_a) begin
      obs_a.push_back({data_a, sof_a, eol_a, eof_a});
      hs_cyc_a.push_back(cyc);
      $display("A cyc %0d px data=%06h sof=%b eol=%b eof=%b", cyc, data_a, sof_a, eol_a, eof_a);
    end
    if (val_b && rdy_b) begin
      obs_b.push_back({data_b, sof_b, eol_b, eof_b});
      hs_cyc_b.push_back(cyc);
      $display("B cyc %0d px data=%06h sof=%b eol=%b eof=%b", cyc, data_b, sof_b, eol_b, eof_b);
    end
    if (done_a) done_cyc_a.push_back(cyc);
    if (done_b) done_cyc_b.push_back(cyc);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b1; en_b = 1'b1; rdy_a = 1'b1; rdy_b = 1'b1;
    produced_a = consumed_a + 100; produced_b = consumed_b + 100;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      total_cnt++; if (rd_a !== 1'b0) $display("FAIL reset_rd_a got %b want 0", rd_a); else pass_cnt++;
      total_cnt++; if (val_a !== 1'b0) $display("FAIL reset_valid_a got %b want 0", val_a); else pass_cnt++;
      total_cnt++; if (done_a !== 1'b0) $display("FAIL reset_done_a got %b want 0", done_a); else pass_cnt++;
      total_cnt++; if (fcnt_a !== 16'd0) $display("FAIL reset_fcount_a got %0d want 0", fcnt_a); else pass_cnt++;
      total_cnt++; if (data_a !== 24'd0) $display("FAIL reset_data_a got %h want 0", data_a); else pass_cnt++;
      total_cnt++; if (rd_b !== 1'b0 || val_b !== 1'b0) $display("FAIL reset_b rd=%b valid=%b want 0 0", rd_b, val_b); else pass_cnt++;
    end
    produced_a = consumed_a; produced_b = consumed_b;
    en_b = 1'b0;
    rst_a = 1'b0; rst_b = 1'b0;
    tick(1);
  endtask

  task automatic test_below_threshold();
    int rb = rd_cyc_a.size();
    int ob = obs_a.size();
    int base = consumed_a;
    int r0, r15, h0;
    logic [26:0] got, exp;
    en_a = 1'b1; rdy_a = 1'b1;
    produced_a = consumed_a + 15;
    tick(50);
    total_cnt++; if (rd_cyc_a.size() != rb) $display("FAIL below_thr_reads got %0d want 0", rd_cyc_a.size() - rb); else pass_cnt++;
    produced_a = consumed_a + 16;
    tick(40);
    total_cnt++; if (rd_cyc_a.size() - rb != 16) $display("FAIL burst_reads got %0d want 16", rd_cyc_a.size() - rb); else pass_cnt++;
    r0  = (rd_cyc_a.size() > rb) ? rd_cyc_a[rb] : -100;
    r15 = (rd_cyc_a.size() > rb + 15) ? rd_cyc_a[rb + 15] : -100;
    h0  = (hs_cyc_a.size() > ob) ? hs_cyc_a[ob] : -100;
    total_cnt++; if (r15 - r0 != 15) $display("FAIL burst_consecutive span got %0d want 15", r15 - r0); else pass_cnt++;
    total_cnt++; if (h0 - r0 != 2) $display("FAIL first_valid_latency got %0d want 2", h0 - r0); else pass_cnt++;
    for (int k = 0; k < 16; k++) begin
      got = 'x;
      if (ob + k < obs_a.size()) got = obs_a[ob + k];
      exp = {src_a[base + k], (k == 0), ((k % WA) == WA - 1), 1'b0};
      total_cnt++; if (got !== exp) $display("FAIL burst1_px%0d got %h want %h", k, got, exp); else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    int rb = rd_cyc_a.size();
    int ob = obs_a.size();
    int db = done_cyc_a.size();
    int base = consumed_a;
    int n = 0, bad = 0, outstanding, last_hs, d0;
    logic [23:0] held;
    logic [26:0] got, exp;
    rdy_a = 1'b1;
    produced_a = consumed_a + 16;
    while (!val_a && n < 30) begin tick(1); n++; end
    total_cnt++; if (val_a !== 1'b1) $display("FAIL bp_wait_valid got %b want 1", val_a); else pass_cnt++;
    tick(1);
    rdy_a = 1'b0;
    tick(1);
    held = data_a;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (data_a !== held || val_a !== 1'b1) bad++;
    end
    total_cnt++; if (bad != 0) $display("FAIL bp_hold_stable got %0d unstable cycles want 0", bad); else pass_cnt++;
    outstanding = (rd_cyc_a.size() - rb) - (obs_a.size() - ob);
    total_cnt++; if (outstanding != 2) $display("FAIL bp_outstanding got %0d want 2", outstanding); else pass_cnt++;
    rdy_a = 1'b1;
    tick(40);
    total_cnt++; if (obs_a.size() - ob != 16) $display("FAIL bp_pixel_count got %0d want 16", obs_a.size() - ob); else pass_cnt++;
    for (int k = 0; k < 16; k++) begin
      got = 'x;
      if (ob + k < obs_a.size()) got = obs_a[ob + k];
      exp = {src_a[base + k], 1'b0, (((16 + k) % WA) == WA - 1), (16 + k == FS_A - 1)};
      total_cnt++; if (got !== exp) $display("FAIL bp_px%0d got %h want %h", k, got, exp); else pass_cnt++;
    end
    last_hs = (hs_cyc_a.size() > ob + 15) ? hs_cyc_a[ob + 15] : -100;
    d0 = (done_cyc_a.size() > db) ? done_cyc_a[db] : -200;
    total_cnt++; if (done_cyc_a.size() - db != 1) $display("FAIL frame_done_pulses got %0d want 1", done_cyc_a.size() - db); else pass_cnt++;
    total_cnt++; if (d0 - last_hs != 1) $display("FAIL frame_done_timing got %0d want 1", d0 - last_hs); else pass_cnt++;
    total_cnt++; if (fcnt_a !== 16'd1) $display("FAIL frame_count_1 got %0d want 1", fcnt_a); else pass_cnt++;
  endtask

  task automatic test_enable_gating();
    int ob = obs_a.size();
    int base = consumed_a;
    int r2, n = 0;
    logic [26:0] got, exp;
    rdy_a = 1'b1; en_a = 1'b1;
    produced_a = consumed_a + 16;
    tick(5);
    en_a = 1'b0;
    produced_a = produced_a + 16;
    tick(100);
    total_cnt++; if (obs_a.size() - ob != FS_A) $display("FAIL en_frame_pixels got %0d want %0d", obs_a.size() - ob, FS_A); else pass_cnt++;
    got = 'x;
    if (ob + FS_A - 1 < obs_a.size()) got = obs_a[ob + FS_A - 1];
    exp = {src_a[base + FS_A - 1], 1'b0, 1'b1, 1'b1};
    total_cnt++; if (got !== exp) $display("FAIL en_last_px got %h want %h", got, exp); else pass_cnt++;
    total_cnt++; if (fcnt_a !== 16'd2) $display("FAIL frame_count_2 got %0d want 2", fcnt_a); else pass_cnt++;
    r2 = rd_cyc_a.size();
    produced_a = consumed_a + 16;
    tick(30);
    total_cnt++; if (rd_cyc_a.size() != r2) $display("FAIL en_gated_reads got %0d want 0", rd_cyc_a.size() - r2); else pass_cnt++;
    en_a = 1'b1;
    while (rd_cyc_a.size() == r2 && n < 10) begin tick(1); n++; end
    total_cnt++; if (rd_cyc_a.size() <= r2) $display("FAIL en_restart got 0 reads want >0"); else pass_cnt++;
    burst_rd_base = r2;
  endtask

  task automatic test_mid_burst_reset();
    int n = 0, ob, db, base, last_hs, d0;
    logic [26:0] got, exp;
    while (rd_cyc_a.size() - burst_rd_base < 5 && n < 20) begin tick(1); n++; end
    total_cnt++; if (rd_cyc_a.size() - burst_rd_base != 5) $display("FAIL rst_reads_before got %0d want 5", rd_cyc_a.size() - burst_rd_base); else pass_cnt++;
    rst_a = 1'b1;
    produced_a = consumed_a;
    tick(1);
    rst_a = 1'b0;
    total_cnt++; if (rd_a !== 1'b0) $display("FAIL rst_rd got %b want 0", rd_a); else pass_cnt++;
    total_cnt++; if (val_a !== 1'b0) $display("FAIL rst_valid got %b want 0", val_a); else pass_cnt++;
    total_cnt++; if ({sof_a, eol_a, eof_a} !== 3'b000) $display("FAIL rst_flags got %b want 000", {sof_a, eol_a, eof_a}); else pass_cnt++;
    total_cnt++; if (data_a !== 24'd0) $display("FAIL rst_data got %h want 0", data_a); else pass_cnt++;
    total_cnt++; if (done_a !== 1'b0) $display("FAIL rst_done got %b want 0", done_a); else pass_cnt++;
    total_cnt++; if (fcnt_a !== 16'd0) $display("FAIL rst_fcount got %0d want 0", fcnt_a); else pass_cnt++;
    ob = obs_a.size(); db = done_cyc_a.size(); base = consumed_a;
    produced_a = consumed_a + FS_A;
    n = 0;
    while (done_cyc_a.size() == db && n < 800) begin
      rdy_a = ($urandom_range(0, 3) != 0);
      tick(1);
      n++;
    end
    rdy_a = 1'b1;
    tick(3);
    total_cnt++; if (obs_a.size() - ob != FS_A) $display("FAIL restart_pixels got %0d want %0d", obs_a.size() - ob, FS_A); else pass_cnt++;
    for (int k = 0; k < FS_A; k++) begin
      got = 'x;
      if (ob + k < obs_a.size()) got = obs_a[ob + k];
      exp = {src_a[base + k], (k == 0), ((k % WA) == WA - 1), (k == FS_A - 1)};
      total_cnt++; if (got !== exp) $display("FAIL restart_px%0d got %h want %h", k, got, exp); else pass_cnt++;
    end
    last_hs = (hs_cyc_a.size() > ob + FS_A - 1) ? hs_cyc_a[ob + FS_A - 1] : -100;
    d0 = (done_cyc_a.size() > db) ? done_cyc_a[db] : -200;
    total_cnt++; if (d0 - last_hs != 1) $display("FAIL restart_done_timing got %0d want 1", d0 - last_hs); else pass_cnt++;
    total_cnt++; if (fcnt_a !== 16'd1) $display("FAIL restart_fcount got %0d want 1", fcnt_a); else pass_cnt++;
  endtask

  task automatic test_small_frame();
    int rb = rd_cyc_b.size();
    int ob = obs_b.size();
    int db = done_cyc_b.size();
    int base = consumed_b;
    int r0, r7, r8, r11, h0, last_hs, d0;
    logic [26:0] got, exp;
    rdy_b = 1'b1; en_b = 1'b1;
    produced_b = consumed_b + 20;
    tick(3);
    en_b = 1'b0;
    tick(97);
    total_cnt++; if (rd_cyc_b.size() - rb != FS_B) $display("FAIL small_reads got %0d want %0d", rd_cyc_b.size() - rb, FS_B); else pass_cnt++;
    r0  = (rd_cyc_b.size() > rb) ? rd_cyc_b[rb] : -100;
    r7  = (rd_cyc_b.size() > rb + 7) ? rd_cyc_b[rb + 7] : -100;
    r8  = (rd_cyc_b.size() > rb + 8) ? rd_cyc_b[rb + 8] : -100;
    r11 = (rd_cyc_b.size() > rb + 11) ? rd_cyc_b[rb + 11] : -100;
    h0  = (hs_cyc_b.size() > ob) ? hs_cyc_b[ob] : -100;
    total_cnt++; if (r7 - r0 != 7) $display("FAIL small_burst8_span got %0d want 7", r7 - r0); else pass_cnt++;
    total_cnt++; if (r8 - r7 < 4) $display("FAIL small_burst_gap got %0d want >=4", r8 - r7); else pass_cnt++;
    total_cnt++; if (r11 - r8 != 3) $display("FAIL small_burst4_span got %0d want 3", r11 - r8); else pass_cnt++;
    total_cnt++; if (h0 - r0 != 2) $display("FAIL small_latency got %0d want 2", h0 - r0); else pass_cnt++;
    for (int k = 0; k < FS_B; k++) begin
      got = 'x;
      if (ob + k < obs_b.size()) got = obs_b[ob + k];
      exp = {src_b[base + k], (k == 0), ((k % WB) == WB - 1), (k == FS_B - 1)};
      total_cnt++; if (got !== exp) $display("FAIL small_px%0d got %h want %h", k, got, exp); else pass_cnt++;
    end
    last_hs = (hs_cyc_b.size() > ob + FS_B - 1) ? hs_cyc_b[ob + FS_B - 1] : -100;
    d0 = (done_cyc_b.size() > db) ? done_cyc_b[db] : -200;
    total_cnt++; if (done_cyc_b.size() - db != 1) $display("FAIL small_done_pulses got %0d want 1", done_cyc_b.size() - db); else pass_cnt++;
    total_cnt++; if (d0 - last_hs != 1) $display("FAIL small_done_timing got %0d want 1", d0 - last_hs); else pass_cnt++;
    total_cnt++; if (fcnt_b !== 16'd1) $display("FAIL small_fcount got %0d want 1", fcnt_b); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int ob = obs_b.size();
    int db = done_cyc_b.size();
    int base = consumed_b;
    int n = 0, hs_end, dj;
    logic [26:0] got, exp;
    en_b = 1'b1;
    produced_b = produced_b + 16;
    while (done_cyc_b.size() - db < 2 && n < 1000) begin
      rdy_b = ($urandom_range(0, 2) != 0);
      tick(1);
      n++;
    end
    rdy_b = 1'b1;
    tick(3);
    total_cnt++; if (obs_b.size() - ob != 2 * FS_B) $display("FAIL b2b_pixels got %0d want %0d", obs_b.size() - ob, 2 * FS_B); else pass_cnt++;
    for (int k = 0; k < 2 * FS_B; k++) begin
      got = 'x;
      if (ob + k < obs_b.size()) got = obs_b[ob + k];
      exp = {src_b[base + k], ((k % FS_B) == 0), ((k % WB) == WB - 1), ((k % FS_B) == FS_B - 1)};
      total_cnt++; if (got !== exp) $display("FAIL b2b_px%0d got %h want %h", k, got, exp); else pass_cnt++;
    end
    for (int j = 0; j < 2; j++) begin
      hs_end = (hs_cyc_b.size() > ob + FS_B * j + FS_B - 1) ? hs_cyc_b[ob + FS_B * j + FS_B - 1] : -100;
      dj = (done_cyc_b.size() > db + j) ? done_cyc_b[db + j] : -200;
      total_cnt++; if (dj - hs_end != 1) $display("FAIL b2b_done%0d_timing got %0d want 1", j, dj - hs_end); else pass_cnt++;
    end
    total_cnt++; if (fcnt_b !== 16'd3) $display("FAIL b2b_fcount got %0d want 3", fcnt_b); else pass_cnt++;
    total_cnt++; if (empty_rd_a != 0) $display("FAIL empty_reads_a got %0d want 0", empty_rd_a); else pass_cnt++;
    total_cnt++; if (empty_rd_b != 0) $display("FAIL empty_reads_b got %0d want 0", empty_rd_b); else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      src_a[i] = 24'($urandom);
      src_b[i] = 24'($urandom);
    end
    test_reset();
    test_below_threshold();
    test_backpressure();
    test_enable_gating();
    test_mid_burst_reset();
    test_small_frame();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sr_frame_reader.md
# sr_frame_reader

Read-side consumer of the super-resolution output FIFO. It watches the FIFO's read-side fill count and drains the FIFO in fixed-length bursts. It re-times the pixels through a 2-entry output buffer and presents them as a valid/ready pixel stream, tagged with start-of-frame, end-of-line and end-of-frame, to the display/SDRAM writer. It counts pixels per frame, pulses `frame_done` after the last pixel of each frame is accepted, and never reads an empty FIFO.

## Interface
Parameters:
- `WIDTH`, 320, pixels per line
- `HEIGHT`, 240, lines per frame
- `PIXEL_WIDTH`, 24, bits per pixel
- `BURST_LEN`, 16, FIFO reads per burst (1..511)
- `COUNT_WIDTH`, 10, width of FIFO fill count

Ports:
- `clk`  in  1  FIFO read clock; sole clock of this block
- `rst`  in  1  synchronous, active-high reset
- `enable`  in  1  permits starting a new frame
- `data_count_r`  in  COUNT_WIDTH  FIFO read-side fill count
- `fifo_dout`  in  PIXEL_WIDTH  FIFO read data, valid the cycle after `rd_fifo`
- `rd_fifo`  out  1  FIFO read strobe
- `m_valid`  out  1  output pixel valid
- `m_ready`  in  1  downstream accepts pixel
- `m_data`  out  PIXEL_WIDTH  output pixel
- `m_sof`  out  1  head pixel is x=0, y=0
- `m_eol`  out  1  head pixel is x=WIDTH-1
- `m_eof`  out  1  head pixel is the last pixel of the frame
- `frame_done`  out  1  one-cycle pulse after the last pixel is accepted
- `frame_count`  out  16  completed frames, wraps at 65535→0

## Operation
- FRAME_SIZE = WIDTH*HEIGHT.
- `issued` counts reads in the frame, 0..FRAME_SIZE.
- `burst_left` counts reads remaining in the current burst.
- x/y counters advance on output handshake (`m_valid && m_ready`).
  - x wraps at WIDTH-1; on wrap, y increments.
- Burst length `blen` = min(BURST_LEN, FRAME_SIZE − issued).
- States:
  - IDLE:
    - If `issued==0`, `enable` must be high to proceed; `enable` is ignored mid-frame.
    - If `data_count_r >= blen`, load `burst_left = blen` and go to BURST.
    - If `issued==FRAME_SIZE`, go to DRAIN.
  - BURST:
    - `rd_fifo` is asserted iff `burst_left>0` and (buffer occupancy + in-flight read − pop this cycle) < 2.
    - Each read decrements `burst_left` and increments `issued`.
    - When `burst_left` reaches 0 (last read issued), go to SETTLE.
  - SETTLE: 2 cycles with no reads, so `data_count_r` reflects the burst. Then go to IDLE, or to DRAIN if `issued==FRAME_SIZE`.
  - DRAIN: wait for handshake of the pixel with `m_eof`, then go to DONE.
  - DONE (1 cycle):
    - `frame_done`=1 and `frame_count`+1.
    - Clear `issued`, x and y.
    - Go to IDLE.
- Output buffer is a 2-entry FIFO.
  - The cycle after each read, `fifo_dout` is written into the buffer.
  - `m_data`/`m_sof`/`m_eol`/`m_eof` come from the head entry; flags are derived from the current x/y.
- The read-issue rule guarantees the buffer never overflows; no data is dropped.
- `rd_fifo` is never asserted when `data_count_r` was insufficient at burst start.

## Timing
- Reset values:
  - `rd_fifo`, `m_valid`, `m_sof`, `m_eol`, `m_eof`, `frame_done` = 0
  - `m_data` = 0; `frame_count` = 0
  - state = IDLE; all counters 0; buffer empty
- Latency: `rd_fifo` in cycle t → `m_valid` in t+2 (capture at end of t+1).
- With `m_ready` held high, sustained throughput within a burst is 1 pixel/cycle.
- Bursts are separated by ≥3 idle cycles (SETTLE + IDLE decision).
- While `m_valid && !m_ready`, `m_data` and the flags are held stable. Within 2 cycles reads stop; at most 2 pixels are buffered.
- Simultaneous push and pop on the buffer are both honoured; occupancy is unchanged.
- `frame_done` goes high the cycle after the `m_eof` handshake.
- `rst` mid-burst: the next cycle returns to reset values. The in-flight read's data is discarded; the FIFO must be reset alongside.
- Widths:
  - `issued` is sized by $clog2(FRAME_SIZE+1).
  - `data_count_r` is compared unsigned, zero-extended to the wider width.

## Test plan
- Reset: assert `rst` 3 cycles with `data_count_r`=100 → `rd_fifo`, `m_valid`, `frame_done` stay 0; `frame_count`=0.
- Below threshold: BURST_LEN=16, `enable`=1, `data_count_r`=15 held → no `rd_fifo` for 50 cycles; raise to 16 → `rd_fifo` high exactly 16 consecutive cycles (`m_ready`=1), first `m_valid` 2 cycles after the first read, data order matches FIFO order.
- Backpressure: `m_ready`=0 after 1 pixel → at most 2 reads outstanding after the stall, `m_data` stable; release → remaining pixels in order, no loss or duplicate.
- Small frame: WIDTH=4, HEIGHT=3, BURST_LEN=8, `data_count_r`=20 → bursts of 8 then 4; `m_sof` on pixel 0; `m_eol` on pixels 3, 7, 11; `m_eof` on pixel 11; `frame_done` pulse 1 cycle after; `frame_count`=1.
- Enable gating: deassert `enable` mid-frame → frame completes; next frame does not start until `enable`=1.
- Mid-burst reset: `rst` for 1 cycle after 5 of 16 reads → outputs return to reset values the next cycle; the next frame restarts with `m_sof` on its first pixel.
